// File: rtl/log_map_phase_ctrl_pkg.sv
// Shared parameters, phase encodings and memory word layout for the log-MAP SISO core.
package log_map_phase_ctrl_pkg;

  localparam int LM_CODELENGTH = 256;
  localparam int LM_ADDRLENGTH = 9;
  localparam int LM_TAIL       = 3;
  localparam int LM_PIPE_LAT   = 2;

  // Branch/state metric word layouts shared with the compute units.
  localparam int METRIC_W      = 8;
  localparam int GAMMA_G0_LSB  = 0;
  localparam int GAMMA_G1_LSB  = METRIC_W;
  localparam int GAMMA_W       = 2 * METRIC_W;
  localparam int ALPHA_LO_LSB  = 0;
  localparam int ALPHA_HI_LSB  = 4 * METRIC_W;
  localparam int BETA_LO_LSB   = 0;
  localparam int BETA_HI_LSB   = 4 * METRIC_W;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FWD   = 3'd1,
    PH_ATERM = 3'd2,
    PH_BTERM = 3'd3,
    PH_BWD   = 3'd4,
    PH_EXT   = 3'd5,
    PH_FLUSH = 3'd6
  } phase_e;

endpackage

// File: rtl/log_map_phase_ctrl_delay_line.sv
// Fixed-depth shift register carrying {wen, addr, valid} to line writes up with compute latency.
module lm_delay_line #(
  parameter int DEPTH = 2,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_wen,
  input  logic [AW-1:0] in_addr,
  input  logic          in_valid,
  output logic          out_wen,
  output logic [AW-1:0] out_addr,
  output logic          out_valid
);

  localparam int DW = AW + 2;

  logic [DW-1:0] pipe_r [DEPTH];

  // Shift the strobe/address word one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_r[i] <= {DW{1'b0}};
    end else begin
      pipe_r[0] <= {in_wen, in_addr, in_valid};
      for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign {out_wen, out_addr, out_valid} = pipe_r[DEPTH-1];

endmodule

// File: rtl/log_map_phase_ctrl.sv
// Phase sequencer for one log-MAP SISO pass: forward, alpha/beta termination, backward, extrinsic.
module log_map_phase_ctrl
  import log_map_phase_ctrl_pkg::*;
#(
  parameter int CODELENGTH = LM_CODELENGTH,
  parameter int ADDRLENGTH = LM_ADDRLENGTH,
  parameter int TAIL       = LM_TAIL,
  parameter int PIPE_LAT   = LM_PIPE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDRLENGTH-1:0] gamma_addr,
  output logic                  gamma_wen,
  output logic [ADDRLENGTH-1:0] alpha_addr,
  output logic                  alpha_wen,
  output logic [ADDRLENGTH-1:0] beta_addr,
  output logic                  beta_wen,
  output logic                  alpha_init,
  output logic                  aterm_init,
  output logic                  bterm_init,
  output logic                  bwd_init,
  output logic [2:0]            phase,
  output logic                  ext_valid
);

  localparam int AW = ADDRLENGTH;
  localparam logic [AW-1:0] ZERO_A       = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A        = AW'(1);
  localparam logic [AW-1:0] K_A          = AW'(CODELENGTH);
  localparam logic [AW-1:0] KM1_A        = AW'(CODELENGTH - 1);
  localparam logic [AW-1:0] KTOP_A       = AW'(CODELENGTH + TAIL - 1);
  localparam logic [AW-1:0] TAIL_A       = AW'(TAIL);
  localparam logic [AW-1:0] LAST_TERM_A  = AW'(TAIL + PIPE_LAT - 1);
  localparam logic [AW-1:0] LAST_BWD_A   = AW'(CODELENGTH + PIPE_LAT - 1);
  localparam logic [AW-1:0] LAST_FLUSH_A = AW'(PIPE_LAT - 1);

  phase_e        state_r;
  phase_e        follow_s;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] last_cnt_s;
  logic          first_r;
  logic          step_s;
  logic          dly_in_wen_s;
  logic [AW-1:0] dly_in_addr_s;
  logic          dly_in_valid_s;
  logic          dly_wen_s;
  logic [AW-1:0] dly_addr_s;
  logic          dly_valid_s;

  // Per-phase terminal count, successor phase and counter-advance condition.
  always_comb begin
    last_cnt_s = ZERO_A;
    follow_s   = PH_IDLE;
    step_s     = 1'b1;
    case (state_r)
      PH_IDLE:  begin last_cnt_s = ZERO_A;       follow_s = PH_FWD;   step_s = start;    end
      PH_FWD:   begin last_cnt_s = KTOP_A;       follow_s = PH_ATERM; step_s = in_valid; end
      PH_ATERM: begin last_cnt_s = LAST_TERM_A;  follow_s = PH_BTERM; end
      PH_BTERM: begin last_cnt_s = LAST_TERM_A;  follow_s = PH_BWD;   end
      PH_BWD:   begin last_cnt_s = LAST_BWD_A;   follow_s = PH_EXT;   end
      PH_EXT:   begin last_cnt_s = KM1_A;        follow_s = PH_FLUSH; end
      PH_FLUSH: begin last_cnt_s = LAST_FLUSH_A; follow_s = PH_IDLE;  end
      default:  begin last_cnt_s = ZERO_A;       follow_s = PH_IDLE;  step_s = 1'b0;     end
    endcase
  end

  // Phase FSM with a single counter cleared on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PH_IDLE;
      cnt_r   <= ZERO_A;
      first_r <= 1'b0;
    end else begin
      first_r <= 1'b0;
      if (step_s) begin
        if (cnt_r == last_cnt_s) begin
          state_r <= follow_s;
          cnt_r   <= ZERO_A;
          first_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + ONE_A;
        end
      end
    end
  end

  // Address/strobe decode; termination and backward writes come out of the delay line.
  always_comb begin
    gamma_addr    = ZERO_A;
    gamma_wen     = 1'b0;
    alpha_addr    = ZERO_A;
    alpha_wen     = 1'b0;
    beta_addr     = ZERO_A;
    beta_wen      = 1'b0;
    alpha_init    = 1'b0;
    aterm_init    = 1'b0;
    bterm_init    = 1'b0;
    bwd_init      = 1'b0;
    dly_in_wen_s  = 1'b0;
    dly_in_addr_s = ZERO_A;
    case (state_r)
      PH_FWD: begin
        alpha_init = first_r;
        gamma_addr = cnt_r;
        gamma_wen  = in_valid;
        alpha_addr = cnt_r;
        alpha_wen  = in_valid && (cnt_r < K_A);
      end
      PH_ATERM: begin
        aterm_init    = first_r;
        dly_in_wen_s  = (cnt_r < TAIL_A);
        dly_in_addr_s = dly_in_wen_s ? (K_A + cnt_r) : KTOP_A;
        gamma_addr    = dly_in_addr_s;
        alpha_addr    = dly_addr_s;
        alpha_wen     = dly_wen_s;
      end
      PH_BTERM: begin
        bterm_init    = first_r;
        dly_in_wen_s  = (cnt_r < TAIL_A);
        dly_in_addr_s = dly_in_wen_s ? (KTOP_A - cnt_r) : K_A;
        gamma_addr    = dly_in_addr_s;
        beta_addr     = dly_addr_s;
        beta_wen      = dly_wen_s;
      end
      PH_BWD: begin
        // Saturate at 0 once the K reads are issued so the counter never wraps.
        bwd_init      = first_r;
        dly_in_wen_s  = (cnt_r < K_A);
        dly_in_addr_s = dly_in_wen_s ? (KM1_A - cnt_r) : ZERO_A;
        gamma_addr    = dly_in_addr_s;
        beta_addr     = dly_addr_s;
        beta_wen      = dly_wen_s;
      end
      PH_EXT: begin
        gamma_addr = cnt_r;
        alpha_addr = cnt_r;
        beta_addr  = cnt_r + ONE_A;
      end
      default: begin
        gamma_addr = ZERO_A;
      end
    endcase
  end

  assign dly_in_valid_s = (state_r == PH_EXT);

  lm_delay_line #(
    .DEPTH (PIPE_LAT),
    .AW    (AW)
  ) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_wen    (dly_in_wen_s),
    .in_addr   (dly_in_addr_s),
    .in_valid  (dly_in_valid_s),
    .out_wen   (dly_wen_s),
    .out_addr  (dly_addr_s),
    .out_valid (dly_valid_s)
  );

  assign ext_valid = dly_valid_s;
  assign busy      = (state_r != PH_IDLE);
  assign done      = (state_r == PH_FLUSH) && (cnt_r == LAST_FLUSH_A);
  assign phase     = state_r;

endmodule

// File: tb/tb_log_map_phase_ctrl.sv
// Directed bench: K=8 build for cycle tables and corner sequences, default K=256 for range checks.
module tb_log_map_phase_ctrl;

  logic clk = 1'b0;
  logic rst_n, start8, start256, in_valid;

  logic busy8, done8, g_wen8, a_wen8, b_wen8, ai8, ati8, bti8, bwi8, ev8;
  logic [3:0] g_addr8, a_addr8, b_addr8;
  logic [2:0] phase8;

  logic busy256, done256, g_wen256, a_wen256, b_wen256, ai256, ati256, bti256, bwi256, ev256;
  logic [8:0] g_addr256, a_addr256, b_addr256;
  logic [2:0] phase256;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  log_map_phase_ctrl #(.CODELENGTH(8), .ADDRLENGTH(4), .TAIL(3), .PIPE_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(in_valid),
    .busy(busy8), .done(done8), .gamma_addr(g_addr8), .gamma_wen(g_wen8),
    .alpha_addr(a_addr8), .alpha_wen(a_wen8), .beta_addr(b_addr8), .beta_wen(b_wen8),
    .alpha_init(ai8), .aterm_init(ati8), .bterm_init(bti8), .bwd_init(bwi8),
    .phase(phase8), .ext_valid(ev8)
  );

  log_map_phase_ctrl dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .in_valid(in_valid),
    .busy(busy256), .done(done256), .gamma_addr(g_addr256), .gamma_wen(g_wen256),
    .alpha_addr(a_addr256), .alpha_wen(a_wen256), .beta_addr(b_addr256), .beta_wen(b_wen256),
    .alpha_init(ai256), .aterm_init(ati256), .bterm_init(bti256), .bwd_init(bwi256),
    .phase(phase256), .ext_valid(ev256)
  );

  typedef struct packed {
    int n; logic [2:0] ph; logic [3:0] ga; logic gw;
    logic ca; logic [3:0] aa; logic aw;
    logic cb; logic [3:0] ba; logic bw;
    logic [3:0] init; logic ev; logic dn; logic by;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(int n, int ph, int ga, int gw, int ca, int aa, int aw,
                              int cb, int ba, int bw, logic [3:0] init, int ev, int dn, int by);
    vec_t v;
    v.n = n; v.ph = 3'(ph); v.ga = 4'(ga); v.gw = 1'(gw);
    v.ca = 1'(ca); v.aa = 4'(aa); v.aw = 1'(aw);
    v.cb = 1'(cb); v.ba = 4'(ba); v.bw = 1'(bw);
    v.init = init; v.ev = 1'(ev); v.dn = 1'(dn); v.by = 1'(by);
    return v;
  endfunction

  // Monitor of the K=8 instance
  int gw_q[$], aw_q[$], bw_q[$], init_q[$];
  int ev_cnt, dn_cnt, bad_wen, multi_init, fwd_cyc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (g_wen8) gw_q.push_back(int'(g_addr8));
      if (a_wen8) aw_q.push_back(int'(a_addr8));
      if (b_wen8) bw_q.push_back(int'(b_addr8));
      if (ev8) ev_cnt++;
      if (done8) dn_cnt++;
      if (phase8 == 3'd1) fwd_cyc++;
      if ((g_wen8 && (phase8 != 3'd1 || !in_valid)) ||
          ((a_wen8 || b_wen8) && (phase8 < 3'd1 || phase8 > 3'd4))) bad_wen++;
      if (int'(ai8) + int'(ati8) + int'(bti8) + int'(bwi8) > 1) multi_init++;
      if (ai8) init_q.push_back(0);
      if (ati8) init_q.push_back(1);
      if (bti8) init_q.push_back(2);
      if (bwi8) init_q.push_back(3);
    end
  end

  task automatic clr_mon();
    gw_q.delete(); aw_q.delete(); bw_q.delete(); init_q.delete();
    ev_cnt = 0; dn_cnt = 0; bad_wen = 0; multi_init = 0; fwd_cyc = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pass(input string tag);
    int e;
    chk({tag, "_gamma_wr_count"}, gw_q.size(), 11);
    e = 0;
    foreach (gw_q[i]) if (gw_q[i] != i) e++;
    chk({tag, "_gamma_wr_order"}, e, 0);
    chk({tag, "_alpha_wr_count"}, aw_q.size(), 11);
    e = 0;
    foreach (aw_q[i]) if (aw_q[i] != i) e++;
    chk({tag, "_alpha_wr_order"}, e, 0);
    chk({tag, "_beta_wr_count"}, bw_q.size(), 11);
    e = 0;
    foreach (bw_q[i]) if (bw_q[i] != 10 - i) e++;
    chk({tag, "_beta_wr_order"}, e, 0);
    chk({tag, "_ext_valid_count"}, ev_cnt, 8);
    chk({tag, "_done_count"}, dn_cnt, 1);
    chk({tag, "_init_count"}, init_q.size(), 4);
    e = 0;
    foreach (init_q[i]) if (init_q[i] != i) e++;
    chk({tag, "_init_order"}, e, 0);
    chk({tag, "_multi_init"}, multi_init, 0);
    chk({tag, "_stray_wen"}, bad_wen, 0);
  endtask

  task automatic kick8();
    clr_mon();
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Runs a K=8 pass from its first FWD cycle; optional mid-pass start poke or reset.
  task automatic do_pass(input bit toggle, input int poke_n, input int rst_at);
    int n;
    bit stop;
    n = 0;
    stop = 1'b0;
    while (!stop) begin
      in_valid = toggle ? (n % 2 == 1) : 1'b1;
      start8 = (n == poke_n);
      @(negedge clk);
      if (n == 0) begin
        chk("first_cycle_phase", int'(phase8), 1);
        chk("first_cycle_alpha_init", int'(ai8), 1);
      end
      if (n == rst_at) begin
        chk("bwd_gamma_addr_at_reset", int'(g_addr8), 3);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({busy8, done8, g_addr8, g_wen8, a_addr8, a_wen8, b_addr8,
                                          b_wen8, ai8, ati8, bti8, bwi8, phase8, ev8}), 0);
        stop = 1'b1;
      end else if (done8) begin
        stop = 1'b1;
      end else if (n >= 200) begin
        checks++;
        failures++;
        $display("FAIL pass_timeout: got no done after %0d cycles expected done", n);
        stop = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mx, bw_n, last_b, exp_b, eb_err, ext_cyc, ev_n, n;
    bit fin, ok;

    rst_n = 1'b0; start8 = 1'b0; start256 = 1'b0; in_valid = 1'b0;
    clr_mon();
    #2;
    chk("reset_outputs_k8", int'({busy8, done8, g_addr8, g_wen8, a_addr8, a_wen8, b_addr8,
                                  b_wen8, ai8, ati8, bti8, bwi8, phase8, ev8}), 0);
    chk("reset_outputs_k256", int'(|{busy256, done256, g_addr256, g_wen256, a_addr256, a_wen256,
                                     b_addr256, b_wen256, ai256, ati256, bti256, bwi256,
                                     phase256, ev256}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //           n  ph ga gw ca aa aw cb ba bw init     ev dn by
    tbl.push_back(mk( 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 4'b1000, 0, 0, 1));
    tbl.push_back(mk( 7, 1, 7, 1, 1, 7, 1, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk( 8, 1, 8, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(10, 1,10, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(11, 2, 8, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(12, 2, 9, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(13, 2,10, 0, 1, 8, 1, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(15, 2,10, 0, 1,10, 1, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(16, 3,10, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(17, 3, 9, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(18, 3, 8, 0, 0, 0, 0, 1,10, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(20, 3, 8, 0, 0, 0, 0, 1, 8, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(21, 4, 7, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(23, 4, 5, 0, 0, 0, 0, 1, 7, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(29, 4, 0, 0, 0, 0, 0, 1, 1, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(30, 4, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(31, 5, 0, 0, 1, 0, 0, 1, 1, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(33, 5, 2, 0, 1, 2, 0, 1, 3, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(mk(38, 5, 7, 0, 1, 7, 0, 1, 8, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(mk(39, 6, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(mk(40, 6, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 1));
    tbl.push_back(mk(41, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0));

    // Straight K=8 pass against the cycle table.
    in_valid = 1'b1;
    kick8();
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      foreach (tbl[i]) begin
        if (tbl[i].n == c) begin
          ok = (phase8 == tbl[i].ph) && (g_addr8 == tbl[i].ga) && (g_wen8 == tbl[i].gw) &&
               (!tbl[i].ca || a_addr8 == tbl[i].aa) && (a_wen8 == tbl[i].aw) &&
               (!tbl[i].cb || b_addr8 == tbl[i].ba) && (b_wen8 == tbl[i].bw) &&
               ({ai8, ati8, bti8, bwi8} == tbl[i].init) && (ev8 == tbl[i].ev) &&
               (done8 == tbl[i].dn) && (busy8 == tbl[i].by);
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL vec_cycle_%0d: got ph=%0d ga=%0d gw=%0d aa=%0d aw=%0d ba=%0d bw=%0d init=%b ev=%0d dn=%0d by=%0d expected ph=%0d ga=%0d gw=%0d aa=%0d aw=%0d ba=%0d bw=%0d init=%b ev=%0d dn=%0d by=%0d",
                     c, phase8, g_addr8, g_wen8, a_addr8, a_wen8, b_addr8, b_wen8,
                     {ai8, ati8, bti8, bwi8}, ev8, done8, busy8,
                     tbl[i].ph, tbl[i].ga, tbl[i].gw, tbl[i].aa, tbl[i].aw, tbl[i].ba,
                     tbl[i].bw, tbl[i].init, tbl[i].ev, tbl[i].dn, tbl[i].by);
          end
        end
      end
      @(posedge clk); #1;
    end
    chk_pass("s1");

    // in_valid toggling 0/1 through FWD.
    kick8();
    do_pass(1'b1, -1, -1);
    chk("s2_fwd_cycles", fwd_cyc, 22);
    chk_pass("s2");

    // Start poked mid-BWD is ignored; start right after done is taken.
    kick8();
    do_pass(1'b0, 25, -1);
    chk_pass("s3");

    // Back-to-back start, then reset during BWD at gamma_addr 3.
    kick8();
    do_pass(1'b0, -1, 25);
    chk("s4_no_done_after_reset", dn_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s4_idle_after_reset", int'(phase8), 0);
    kick8();
    do_pass(1'b0, -1, -1);
    chk_pass("s4");

    // Default build, K=256.
    mx = 0; bw_n = 0; last_b = -1; exp_b = 1; eb_err = 0; ext_cyc = 0; ev_n = 0; n = 0;
    fin = 1'b0;
    in_valid = 1'b1;
    start256 = 1'b1;
    @(posedge clk); #1;
    start256 = 1'b0;
    while (!fin && n < 2000) begin
      @(negedge clk);
      if (int'(g_addr256) > mx) mx = int'(g_addr256);
      if (int'(a_addr256) > mx) mx = int'(a_addr256);
      if (int'(b_addr256) > mx) mx = int'(b_addr256);
      if (b_wen256) begin bw_n++; last_b = int'(b_addr256); end
      if (phase256 == 3'd5) begin
        if (int'(b_addr256) != exp_b) eb_err++;
        exp_b++;
        ext_cyc++;
      end
      if (ev256) ev_n++;
      if (done256) fin = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("s5_done_seen", int'(fin), 1);
    chk("s5_last_beta_wr_addr", last_b, 0);
    chk("s5_beta_wr_count", bw_n, 259);
    chk("s5_ext_cycles", ext_cyc, 256);
    chk("s5_ext_beta_addr_seq", eb_err, 0);
    chk("s5_max_addr", mx, 258);
    chk("s5_ext_valid_count", ev_n, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
